// File: rtl/dcache.sv
// dcache: two-way set-associative, write-back, write-allocate L1 data cache.
// The CPU side issues one outstanding word request (read or write pulse).
// The memory side refills whole 256-bit lines. Dirty victims drain through
// a small write-back FIFO that stays searchable until each entry is written back.
//
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   cpu_rreq_i/wreq_i   request pulses; virtual_addr_i / cpu_wdata_i valid with them
//   hit_o               response came from arrays/FIFO (1) or from refill (0)
//   cpu_data_valid_o    read response valid; cpu_data_o holds the last read word
//   mem_ren_o           refill request, address mem_araddr_o, answered by mem_rvalid_i/mem_rdata_i
//   mem_wen_o           write-back request for the FIFO head (mem_awaddr_o/mem_wdata_o)
//   mem_bvalid_i        write-back complete, pops the FIFO head
//   dirty               per {set,way} dirty flags
module dcache #(
    parameter int FIFO_DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         cpu_rreq_i,
    input  logic         cpu_wreq_i,
    input  logic [31:0]  virtual_addr_i,
    input  logic [31:0]  cpu_wdata_i,
    output logic         hit_o,
    output logic         cpu_data_valid_o,
    output logic [31:0]  cpu_data_o,
    input  logic         mem_rvalid_i,
    input  logic [255:0] mem_rdata_i,
    output logic         mem_ren_o,
    output logic [31:0]  mem_araddr_o,
    input  logic         mem_bvalid_i,
    output logic         mem_wen_o,
    output logic [255:0] mem_wdata_o,
    output logic [31:0]  mem_awaddr_o,
    output logic [255:0] dirty
);
    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

    typedef enum logic [2:0] {IDLE, LOOKUP, FRESP, EVICT, REFILL} state_t;
    state_t state, state_n;

    logic [31:2]  addr_q;
    logic [31:0]  wdata_q;
    logic         wr_q;
    logic [31:0]  rdata_q;

    logic [255:0] valid;
    logic [127:0] lru;             // way to evict next in each set
    logic [19:0]  tag_mem  [256];
    logic [255:0] data_mem [256];

    logic [26:0]     fifo_addr [FIFO_DEPTH];
    logic [255:0]    fifo_data [FIFO_DEPTH];
    logic [FIFO_DEPTH-1:0] fifo_vld;
    logic [PW-1:0]   head, tail, fidx, fidx_q;
    logic [PW:0]     count;

    logic [19:0]  tag;
    logic [6:0]   set;
    logic [2:0]   word;
    logic         hit0, hit1, array_hit, victim, need_push, fifo_full;
    logic         fhit, push, pop, fifo_conflict;
    logic [7:0]   hidx, vidx;
    logic [255:0] hit_line;

    function automatic logic [255:0] put_word(input logic [255:0] line, input logic [2:0] w,
                                              input logic [31:0] d);
        logic [255:0] r;
        r = line;
        r[{w, 5'b0} +: 32] = d;
        return r;
    endfunction

    assign tag       = addr_q[31:12];
    assign set       = addr_q[11:5];
    assign word      = addr_q[4:2];
    assign hit0      = valid[{set, 1'b0}] && (tag_mem[{set, 1'b0}] == tag);
    assign hit1      = valid[{set, 1'b1}] && (tag_mem[{set, 1'b1}] == tag);
    assign array_hit = hit0 | hit1;
    assign hidx      = {set, hit1};
    assign hit_line  = data_mem[hidx];
    assign victim    = !valid[{set, 1'b0}] ? 1'b0 : (!valid[{set, 1'b1}] ? 1'b1 : lru[set]);
    assign vidx      = {set, victim};
    assign need_push = valid[vidx] && dirty[vidx];

    assign fifo_full = (count == (PW + 1)'(FIFO_DEPTH));
    assign tail      = PW'((int'(head) + int'(count)) % FIFO_DEPTH);
    assign pop       = mem_bvalid_i && (count != '0);
    assign push      = (state == EVICT) && need_push && (!fifo_full || pop);
    // A pending FIFO write whose target is popped this very cycle loses its
    // entry; it is replayed as an ordinary miss instead.
    assign fifo_conflict = wr_q && mem_bvalid_i && (fidx_q == head);

    assign mem_wen_o    = (count != '0);
    assign mem_awaddr_o = mem_wen_o ? {fifo_addr[head], 5'b0} : '0;
    assign mem_wdata_o  = mem_wen_o ? fifo_data[head] : '0;
    assign mem_araddr_o = (state == REFILL) ? {addr_q[31:5], 5'b0} : '0;

    // The head entry is skipped while it is being popped, so a match there
    // falls through to a refill from memory.
    always_comb begin
        fhit = 1'b0;
        fidx = '0;
        for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
            if (fifo_vld[i] && (fifo_addr[i] == addr_q[31:5]) &&
                !(mem_bvalid_i && (PW'(i) == head))) begin
                fhit = 1'b1;
                fidx = PW'(i);
            end
        end
    end

    always_comb begin
        state_n          = state;
        hit_o            = 1'b0;
        cpu_data_valid_o = 1'b0;
        cpu_data_o       = rdata_q;
        mem_ren_o        = 1'b0;
        case (state)
            IDLE: if (cpu_rreq_i || cpu_wreq_i) state_n = LOOKUP;
            LOOKUP: begin
                if (array_hit) begin
                    hit_o = 1'b1;
                    if (!wr_q) begin
                        cpu_data_valid_o = 1'b1;
                        cpu_data_o       = hit_line[{word, 5'b0} +: 32];
                    end
                    state_n = IDLE;
                end else if (fhit) begin
                    state_n = FRESP;
                end else begin
                    state_n = EVICT;
                end
            end
            FRESP: begin
                if (fifo_conflict) begin
                    state_n = EVICT;
                end else begin
                    hit_o = 1'b1;
                    if (!wr_q) begin
                        cpu_data_valid_o = 1'b1;
                        cpu_data_o       = fifo_data[fidx_q][{word, 5'b0} +: 32];
                    end
                    state_n = IDLE;
                end
            end
            EVICT: if (!(need_push && fifo_full && !mem_bvalid_i)) state_n = REFILL;
            REFILL: begin
                mem_ren_o = 1'b1;
                if (mem_rvalid_i) begin
                    if (!wr_q) begin
                        cpu_data_valid_o = 1'b1;
                        cpu_data_o       = mem_rdata_i[{word, 5'b0} +: 32];
                    end
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            addr_q   <= '0;
            wdata_q  <= '0;
            wr_q     <= 1'b0;
            rdata_q  <= '0;
            valid    <= '0;
            dirty    <= '0;
            lru      <= '0;
            head     <= '0;
            count    <= '0;
            fifo_vld <= '0;
            fidx_q   <= '0;
        end else begin
            state <= state_n;
            if (cpu_data_valid_o) rdata_q <= cpu_data_o;
            if (state == IDLE && (cpu_rreq_i || cpu_wreq_i)) begin
                addr_q  <= virtual_addr_i[31:2];
                wdata_q <= cpu_wdata_i;
                wr_q    <= cpu_wreq_i;
            end
            if (state == LOOKUP) fidx_q <= fidx;
            if (state == LOOKUP && array_hit && wr_q) begin
                dirty[hidx] <= 1'b1;
                lru[set]    <= ~hit1;
            end
            if (state == REFILL && mem_rvalid_i) begin
                valid[vidx] <= 1'b1;
                dirty[vidx] <= wr_q;
                lru[set]    <= ~victim;
            end
            if (pop) begin
                fifo_vld[head] <= 1'b0;
                head <= (head == PW'(FIFO_DEPTH - 1)) ? '0 : head + 1'b1;
            end
            if (push) fifo_vld[tail] <= 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (state == LOOKUP && array_hit && wr_q)
            data_mem[hidx] <= put_word(hit_line, word, wdata_q);
        if (state == REFILL && mem_rvalid_i) begin
            data_mem[vidx] <= wr_q ? put_word(mem_rdata_i, word, wdata_q) : mem_rdata_i;
            tag_mem[vidx]  <= tag;
        end
        if (state == FRESP && wr_q && !fifo_conflict)
            fifo_data[fidx_q] <= put_word(fifo_data[fidx_q], word, wdata_q);
        if (push) begin
            fifo_addr[tail] <= {tag_mem[vidx], set};
            fifo_data[tail] <= data_mem[vidx];
        end
    end
endmodule

// File: tb/tb_dcache.sv
// Randomized bench for dcache. The reference model treats the cache as a
// transparent word memory (gold) over a backing memory (back) that only
// changes on write-back pops, plus a line-level view of which lines sit in
// which set/way and in the write-back queue, to predict hit/miss and dirty.
module tb_dcache;
    localparam int DEPTH = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic         cpu_rreq_i, cpu_wreq_i;
    logic [31:0]  virtual_addr_i, cpu_wdata_i;
    logic         hit_o, cpu_data_valid_o;
    logic [31:0]  cpu_data_o;
    logic         mem_rvalid_i;
    logic [255:0] mem_rdata_i;
    logic         mem_ren_o;
    logic [31:0]  mem_araddr_o;
    logic         mem_bvalid_i;
    logic         mem_wen_o;
    logic [255:0] mem_wdata_o;
    logic [31:0]  mem_awaddr_o;
    logic [255:0] dirty;

    dcache #(.FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst),
        .cpu_rreq_i(cpu_rreq_i), .cpu_wreq_i(cpu_wreq_i),
        .virtual_addr_i(virtual_addr_i), .cpu_wdata_i(cpu_wdata_i),
        .hit_o(hit_o), .cpu_data_valid_o(cpu_data_valid_o), .cpu_data_o(cpu_data_o),
        .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i),
        .mem_ren_o(mem_ren_o), .mem_araddr_o(mem_araddr_o),
        .mem_bvalid_i(mem_bvalid_i), .mem_wen_o(mem_wen_o),
        .mem_wdata_o(mem_wdata_o), .mem_awaddr_o(mem_awaddr_o),
        .dirty(dirty)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    logic [31:0] gold [logic [29:0]];
    logic [31:0] back [logic [29:0]];
    bit          m_vld [128][2];
    bit          m_dty [128][2];
    logic [19:0] m_tag [128][2];
    bit          m_lru [128];
    logic [26:0] m_fifo [$];

    bit          last_hit, last_ren;
    logic [31:0] last_data;

    function automatic logic [31:0] dflt(input logic [29:0] wa);
        return ({wa, 2'b00} * 32'h9E3779B1) ^ 32'h5A5A0F0F;
    endfunction
    function automatic logic [31:0] gw(input logic [29:0] wa);
        return gold.exists(wa) ? gold[wa] : dflt(wa);
    endfunction
    function automatic logic [31:0] bw(input logic [29:0] wa);
        return back.exists(wa) ? back[wa] : dflt(wa);
    endfunction
    function automatic logic [255:0] gline(input logic [26:0] la);
        logic [255:0] l;
        for (int k = 0; k < 8; k++) l[32*k +: 32] = gw({la, 3'(k)});
        return l;
    endfunction
    function automatic logic [255:0] bline(input logic [26:0] la);
        logic [255:0] l;
        for (int k = 0; k < 8; k++) l[32*k +: 32] = bw({la, 3'(k)});
        return l;
    endfunction
    function automatic logic [255:0] m_dirty();
        logic [255:0] d;
        for (int s = 0; s < 128; s++)
            for (int w = 0; w < 2; w++) d[s*2 + w] = m_dty[s][w];
        return d;
    endfunction

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int s = 0; s < 128; s++) begin
            m_lru[s] = 0;
            for (int w = 0; w < 2; w++) begin m_vld[s][w] = 0; m_dty[s][w] = 0; m_tag[s][w] = '0; end
        end
        m_fifo.delete();
        gold = back;
    endtask

    // Called at negedge+1 while mem_bvalid_i is being driven high for one cycle.
    task automatic model_pop();
        logic [26:0] la;
        la = m_fifo.pop_front();
        chk("pop_wen", mem_wen_o, 1);
        chk("pop_awaddr", mem_awaddr_o, {la, 5'b0});
        chk("pop_wdata", mem_wdata_o, gline(la));
        for (int k = 0; k < 8; k++) back[{la, 3'(k)}] = gw({la, 3'(k)});
    endtask

    task automatic do_pop();
        @(negedge clk);
        if (m_fifo.size() != 0) begin
            mem_bvalid_i = 1'b1;
            #1 model_pop();
            @(negedge clk);
            mem_bvalid_i = 1'b0;
        end
    endtask

    task automatic check_static();
        @(negedge clk);
        #1;
        chk("idle_wen", mem_wen_o, m_fifo.size() != 0);
        if (m_fifo.size() != 0) begin
            chk("idle_awaddr", mem_awaddr_o, {m_fifo[0], 5'b0});
            chk("idle_wdata", mem_wdata_o, gline(m_fifo[0]));
        end
        chk("idle_dirty", dirty, m_dirty());
        chk("idle_quiet", {hit_o, cpu_data_valid_o, mem_ren_o}, 3'b000);
    endtask

    task automatic do_req(input logic [31:0] a, input bit wr, input logic [31:0] wd);
        logic [19:0] t;
        logic [6:0]  s;
        logic [26:0] la;
        logic [29:0] wa;
        int way, v;
        bit in_fifo, exp_hit, done;
        t = a[31:12]; s = a[11:5]; la = a[31:5]; wa = a[31:2];
        way = -1; in_fifo = 0; done = 0;
        for (int w = 0; w < 2; w++) if (m_vld[s][w] && m_tag[s][w] == t) way = w;
        foreach (m_fifo[i]) if (m_fifo[i] == la) in_fifo = 1;
        exp_hit = (way >= 0) || in_fifo;
        last_hit = 0; last_ren = 0;

        @(negedge clk);
        cpu_rreq_i = !wr; cpu_wreq_i = wr; virtual_addr_i = a; cpu_wdata_i = wd;
        @(negedge clk);
        cpu_rreq_i = 0; cpu_wreq_i = 0; virtual_addr_i = $urandom; cpu_wdata_i = $urandom;
        for (int cyc = 0; cyc < 40 && !done; cyc++) begin
            if (cyc > 0) begin @(negedge clk); mem_bvalid_i = 1'b0; end
            #1;
            if (hit_o) begin
                chk("hit_pred", 1, exp_hit);
                chk("hit_valid", cpu_data_valid_o, !wr);
                if (!wr) chk("hit_data", cpu_data_o, gw(wa));
                last_hit = 1; last_data = cpu_data_o;
                if (wr) begin
                    gold[wa] = wd;
                    if (way >= 0) begin m_dty[s][way] = 1; m_lru[s] = (way == 0); end
                end
                done = 1;
            end else if (cpu_data_valid_o) begin
                chk("stray_valid", cpu_data_valid_o, 0);
            end else if (mem_ren_o) begin
                chk("miss_pred", exp_hit, 0);
                chk("araddr", mem_araddr_o, {la, 5'b0});
                v = !m_vld[s][0] ? 0 : (!m_vld[s][1] ? 1 : int'(m_lru[s]));
                if (m_vld[s][v] && m_dty[s][v]) m_fifo.push_back({m_tag[s][v], s});
                repeat ($urandom_range(0, 3)) @(negedge clk);
                mem_rvalid_i = 1'b1; mem_rdata_i = bline(la);
                #1;
                chk("refill_hit", hit_o, 0);
                chk("refill_valid", cpu_data_valid_o, !wr);
                if (!wr) chk("refill_data", cpu_data_o, gw(wa));
                last_data = cpu_data_o; last_ren = 1;
                @(negedge clk);
                mem_rvalid_i = 1'b0; mem_rdata_i = '0;
                m_vld[s][v] = 1; m_tag[s][v] = t; m_dty[s][v] = wr; m_lru[s] = (v == 0);
                if (wr) gold[wa] = wd;
                done = 1;
            end else if (cyc >= 4 && mem_wen_o && m_fifo.size() == DEPTH) begin
                mem_bvalid_i = 1'b1;
                model_pop();
            end
        end
        mem_bvalid_i = 1'b0;
        if (!done) chk("req_timeout", 0, 1);
    endtask

    logic [255:0] pat;
    logic [255:0] pat_w;
    logic [19:0]  tags [5];

    initial begin
        pat   = 256'h12345678_91023456_78910234_56789102_34567891_02345678_91023456_78910234;
        pat_w = 256'h12345678_91023456_78910234_22222222_34567891_02345678_91023456_78910234;
        rst = 1; cpu_rreq_i = 0; cpu_wreq_i = 0; virtual_addr_i = '0; cpu_wdata_i = '0;
        mem_rvalid_i = 0; mem_rdata_i = '0; mem_bvalid_i = 0;
        foreach (tags[i]) tags[i] = 20'(32'h00100 * (i + 1) + 32'h3);
        for (int k = 0; k < 8; k++) begin
            back[{27'h0000D000 >> 5, 3'(k)}] = pat[32*k +: 32];
            back[{27'(32'h24687560 >> 5), 3'(k)}] = pat[32*k +: 32];
            back[{27'(32'h59687560 >> 5), 3'(k)}] = pat[32*k +: 32];
            back[{27'(32'h11687560 >> 5), 3'(k)}] = pat[32*k +: 32];
        end
        model_reset();
        repeat (2) @(negedge clk);
        #1;
        chk("reset_outputs", {hit_o, cpu_data_valid_o, cpu_data_o, mem_ren_o, mem_araddr_o, mem_wen_o, mem_awaddr_o}, '0);
        chk("reset_dirty", dirty, '0);
        chk("reset_wdata", mem_wdata_o, '0);
        @(negedge clk);
        rst = 0;

        do_req(32'h0000D000, 0, '0);
        chk("cold_ren", last_ren, 1);
        chk("cold_hit", last_hit, 0);
        chk("cold_data", last_data, 32'h78910234);
        check_static();

        do_req(32'h24687570, 1, 32'h11111111);
        check_static();
        chk("wmiss_dirty86", dirty[86], 1);

        do_req(32'h24687570, 1, 32'h22222222);
        chk("whit_hit", last_hit, 1);
        check_static();
        do_req(32'h24687570, 0, '0);
        chk("rhit_hit", last_hit, 1);
        chk("rhit_data", last_data, 32'h22222222);
        check_static();

        do_req(32'h59687570, 0, '0);
        chk("way1_hit", last_hit, 0);
        chk("way1_data", last_data, 32'h56789102);
        check_static();
        do_req(32'h11687570, 0, '0);
        check_static();
        chk("evict_wen", mem_wen_o, 1);
        chk("evict_awaddr", mem_awaddr_o, 32'h24687560);
        chk("evict_data", last_data, 32'h56789102);

        do_req(32'h24687570, 0, '0);
        chk("fifo_rd_hit", last_hit, 1);
        chk("fifo_rd_noren", last_ren, 0);
        chk("fifo_rd_data", last_data, 32'h22222222);
        check_static();
        do_req(32'h24687570, 1, 32'h22222222);
        chk("fifo_wr_hit", last_hit, 1);
        check_static();
        chk("fifo_wr_wdata", mem_wdata_o, pat_w);

        do_pop();
        check_static();
        chk("drained_wen", mem_wen_o, 0);

        // reset in the middle of a refill
        @(negedge clk);
        cpu_rreq_i = 1; virtual_addr_i = 32'h77700000;
        @(negedge clk);
        cpu_rreq_i = 0;
        for (int i = 0; i < 10 && !mem_ren_o; i++) @(negedge clk);
        #1 chk("rst_ren_seen", mem_ren_o, 1);
        rst = 1;
        #1;
        chk("rst_mid_outputs", {hit_o, cpu_data_valid_o, cpu_data_o, mem_ren_o, mem_araddr_o, mem_wen_o, mem_awaddr_o}, '0);
        chk("rst_mid_dirty", dirty, '0);
        @(negedge clk);
        rst = 0;
        model_reset();
        do_req(32'h24687570, 0, '0);
        chk("post_rst_miss", last_ren, 1);
        chk("post_rst_data", last_data, 32'h22222222);
        check_static();

        for (int n = 0; n < 400; n++) begin
            logic [31:0] a;
            a = {tags[$urandom_range(0, 4)], 7'($urandom_range(0, 1) * 7'h15), 3'($urandom), 2'($urandom)};
            if ($urandom_range(0, 2) == 0) do_pop();
            do_req(a, 1'($urandom), $urandom);
            check_static();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
